// File: rtl/rheed_frame_scheduler_if.sv
// rheed_frame_scheduler_if: control/status bundle between the camera framing
// logic, the frame scheduler and the inference top.
//   master : drives enable/decim/cfg_*/cam_*/res_beat and observes scheduler outputs
//   slave  : the scheduler; drives ap_start, crop_*, frame_gate, pipe_rst, busy,
//            result_pulse, timeout_err and the statistics counters
interface rheed_frame_scheduler_if #(
  parameter int unsigned IN_ROWS = 100,
  parameter int unsigned IN_COLS = 160,
  parameter int unsigned CNT_W   = 16
);
  localparam int unsigned XW = $clog2(IN_COLS);
  localparam int unsigned YW = $clog2(IN_ROWS);

  logic             enable;
  logic [7:0]       decim;
  logic [XW-1:0]    cfg_crop_x0;
  logic [YW-1:0]    cfg_crop_y0;
  logic             cfg_update;
  logic             cam_sof;
  logic             cam_eof;
  logic             res_beat;
  logic             ap_start;
  logic [XW-1:0]    crop_x0;
  logic [YW-1:0]    crop_y0;
  logic             frame_gate;
  logic             pipe_rst;
  logic             busy;
  logic             result_pulse;
  logic             timeout_err;
  logic [CNT_W-1:0] frames_seen;
  logic [CNT_W-1:0] frames_run;
  logic [CNT_W-1:0] frames_dropped;

  modport master (
    output enable, decim, cfg_crop_x0, cfg_crop_y0, cfg_update, cam_sof, cam_eof, res_beat,
    input  ap_start, crop_x0, crop_y0, frame_gate, pipe_rst, busy, result_pulse, timeout_err,
           frames_seen, frames_run, frames_dropped
  );

  modport slave (
    input  enable, decim, cfg_crop_x0, cfg_crop_y0, cfg_update, cam_sof, cam_eof, res_beat,
    output ap_start, crop_x0, crop_y0, frame_gate, pipe_rst, busy, result_pulse, timeout_err,
           frames_seen, frames_run, frames_dropped
  );
endinterface

// File: rtl/rheed_frame_scheduler.sv
// rheed_frame_scheduler: frame-level controller for the RHEED inference pipeline.
// Picks which camera frames are launched (decimation), issues ap_start, gates the
// stream, applies crop updates at frame boundaries and flushes on a result timeout.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of rheed_frame_scheduler_if (config, framing, result
//                handshake in; launch/gate/flush controls and statistics out)
// All outputs are registered; controls are registered from the next state so they
// line up with the state they belong to.
module rheed_frame_scheduler #(
  parameter int unsigned IN_ROWS        = 100,
  parameter int unsigned IN_COLS        = 160,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned FLUSH_CYCLES   = 16,
  parameter int unsigned CNT_W          = 16
) (
  input logic                    clk,
  input logic                    reset,
  rheed_frame_scheduler_if.slave bus
);
  localparam int unsigned XW      = $clog2(IN_COLS);
  localparam int unsigned YW      = $clog2(IN_ROWS);
  localparam int unsigned TMR_MAX = (TIMEOUT_CYCLES > FLUSH_CYCLES) ? TIMEOUT_CYCLES : FLUSH_CYCLES;
  localparam int unsigned TW      = $clog2(TMR_MAX + 1);
  localparam logic [TW-1:0]    TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]    FL_LAST = TW'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_SOF, S_ARM, S_STREAM, S_RESULT, S_FLUSH
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_dec_cnt;
  logic [TW-1:0]    r_tmr;           // timeout count in STREAM/RESULT, flush count in FLUSH
  logic [XW-1:0]    r_pend_x, r_crop_x;
  logic [YW-1:0]    r_pend_y, r_crop_y;
  logic             r_pend_flag;
  logic             r_ap_start, r_frame_gate, r_pipe_rst, r_busy;
  logic             r_result_pulse, r_timeout_err, r_en_d;
  logic [CNT_W-1:0] r_seen, r_run, r_drop;

  logic w_launch, w_skip, w_accept, w_timeout, w_expired;
  logic w_ap_start_nxt, w_gate_nxt, w_pipe_rst_nxt, w_busy_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_SAT) ? v : v + CNT_W'(1);
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and event decode
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_skip      = 1'b0;
    w_accept    = 1'b0;
    w_timeout   = 1'b0;
    w_expired   = (r_tmr == TO_LAST);
    case (r_state)
      S_IDLE: begin
        if (bus.enable) w_state_nxt = S_WAIT_SOF;
      end
      S_WAIT_SOF: begin
        if (!bus.enable) begin
          w_state_nxt = S_IDLE;
        end else if (bus.cam_sof) begin
          if (r_dec_cnt == 8'd0) begin
            w_launch    = 1'b1;
            w_state_nxt = S_ARM;
          end else begin
            w_skip = 1'b1;
          end
        end
      end
      S_ARM: w_state_nxt = S_STREAM;
      S_STREAM: begin
        if (w_expired) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_FLUSH;
        end else if (bus.cam_eof) begin
          w_state_nxt = S_RESULT;
        end
        w_skip = bus.cam_sof && bus.enable;
      end
      S_RESULT: begin
        // A result on the expiry cycle still counts as on time
        if (bus.res_beat) begin
          w_accept    = 1'b1;
          w_state_nxt = bus.enable ? S_WAIT_SOF : S_IDLE;
        end else if (w_expired) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_FLUSH;
        end
        w_skip = bus.cam_sof && bus.enable;
      end
      S_FLUSH: begin
        if (r_tmr == FL_LAST) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_ap_start_nxt = (w_state_nxt == S_ARM);
    w_gate_nxt     = (w_state_nxt == S_ARM) || (w_state_nxt == S_STREAM);
    w_pipe_rst_nxt = (w_state_nxt == S_FLUSH);
    w_busy_nxt     = (w_state_nxt != S_IDLE) && (w_state_nxt != S_WAIT_SOF);
  end

  // Datapath, configuration, status and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dec_cnt      <= '0;
      r_tmr          <= '0;
      r_pend_x       <= '0;
      r_pend_y       <= '0;
      r_pend_flag    <= 1'b0;
      r_crop_x       <= '0;
      r_crop_y       <= '0;
      r_ap_start     <= 1'b0;
      r_frame_gate   <= 1'b0;
      r_pipe_rst     <= 1'b0;
      r_busy         <= 1'b0;
      r_result_pulse <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_en_d         <= 1'b0;
      r_seen         <= '0;
      r_run          <= '0;
      r_drop         <= '0;
    end else begin
      r_ap_start     <= w_ap_start_nxt;
      r_frame_gate   <= w_gate_nxt;
      r_pipe_rst     <= w_pipe_rst_nxt;
      r_busy         <= w_busy_nxt;
      r_result_pulse <= w_accept;
      r_en_d         <= bus.enable;

      if (w_launch)                                r_dec_cnt <= bus.decim;
      else if (w_skip && r_state == S_WAIT_SOF)    r_dec_cnt <= r_dec_cnt - 8'd1;

      // One counter serves both the result timeout and the flush length
      if (r_state == S_ARM || (w_state_nxt == S_FLUSH && r_state != S_FLUSH))
        r_tmr <= '0;
      else if (r_state == S_STREAM || r_state == S_RESULT || r_state == S_FLUSH)
        r_tmr <= r_tmr + TW'(1);

      // ARM consumes the pending values before a same-cycle update lands
      if (r_state == S_ARM && r_pend_flag) begin
        r_crop_x <= r_pend_x;
        r_crop_y <= r_pend_y;
      end
      if (bus.cfg_update) begin
        r_pend_x    <= bus.cfg_crop_x0;
        r_pend_y    <= bus.cfg_crop_y0;
        r_pend_flag <= 1'b1;
      end else if (r_state == S_ARM) begin
        r_pend_flag <= 1'b0;
      end

      if (w_timeout)                  r_timeout_err <= 1'b1;
      else if (r_en_d && !bus.enable) r_timeout_err <= 1'b0;

      if (bus.cam_sof && bus.enable && r_state != S_FLUSH) r_seen <= sat_inc(r_seen);
      if (r_state == S_ARM)                                r_run  <= sat_inc(r_run);
      if (w_skip)                                          r_drop <= sat_inc(r_drop);
    end
  end

  assign bus.ap_start       = r_ap_start;
  assign bus.crop_x0        = r_crop_x;
  assign bus.crop_y0        = r_crop_y;
  assign bus.frame_gate     = r_frame_gate;
  assign bus.pipe_rst       = r_pipe_rst;
  assign bus.busy           = r_busy;
  assign bus.result_pulse   = r_result_pulse;
  assign bus.timeout_err    = r_timeout_err;
  assign bus.frames_seen    = r_seen;
  assign bus.frames_run     = r_run;
  assign bus.frames_dropped = r_drop;
endmodule

// File: tb/tb_rheed_frame_scheduler.sv
// tb_rheed_frame_scheduler: self-checking bench for rheed_frame_scheduler using a
// frame-level reference model (decimation phase, pending/active crop, counters).
module tb_rheed_frame_scheduler;
  localparam int unsigned TO = 500;
  localparam int unsigned FL = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rheed_frame_scheduler_if #(.IN_ROWS(100), .IN_COLS(160), .CNT_W(16)) bus ();

  rheed_frame_scheduler #(
    .IN_ROWS(100), .IN_COLS(160), .TIMEOUT_CYCLES(TO), .FLUSH_CYCLES(FL), .CNT_W(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Frame-level reference model
  int         m_seen, m_run, m_drop, m_dec, m_decim;
  logic [7:0] m_px, m_cx;
  logic [6:0] m_py, m_cy;
  bit         m_pflag;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_seen = 0; m_run = 0; m_drop = 0; m_dec = 0;
    m_px = '0; m_py = '0; m_cx = '0; m_cy = '0; m_pflag = 0;
  endtask

  task automatic set_decim(input int d);
    bus.decim = 8'(d);
    m_decim   = d;
  endtask

  // One frame arriving in WAIT_SOF: 1 of every decim+1 frames is launched
  task automatic model_frame(input bit cfg_mid, input bit cfg_arm, input logic [7:0] nx,
                             input logic [6:0] ny, output bit run);
    m_seen++;
    run = (m_dec == 0);
    if (run) begin
      m_run++;
      m_dec = m_decim;
      if (m_pflag) begin m_cx = m_px; m_cy = m_py; m_pflag = 0; end
    end else begin
      m_drop++;
      m_dec--;
    end
    if (cfg_mid || cfg_arm) begin m_px = nx; m_py = ny; m_pflag = 1; end
  endtask

  // Drive one camera frame; observations are returned for the caller to check
  task automatic drive_frame(input bit run, input int len, input int res_dly,
                             input bit cfg_mid, input bit cfg_arm,
                             input logic [7:0] nx, input logic [6:0] ny,
                             output bit ap, output bit ap_next, output bit gate,
                             output bit gate_end, output logic [7:0] cx,
                             output logic [6:0] cy, output bit stable, output bit res);
    bus.cfg_crop_x0 = nx;
    bus.cfg_crop_y0 = ny;
    bus.cam_sof = 1'b1;
    tick();
    bus.cam_sof = 1'b0;
    ap   = bus.ap_start;
    gate = bus.frame_gate;
    bus.cfg_update = cfg_arm;
    tick();
    bus.cfg_update = 1'b0;
    ap_next = bus.ap_start;
    cx = bus.crop_x0;
    cy = bus.crop_y0;
    stable = 1;
    for (int i = 0; i < len; i++) begin
      bus.cfg_update = cfg_mid && (i == len / 2);
      bus.cam_eof    = (i == len - 1);
      tick();
      if (bus.crop_x0 !== cx || bus.crop_y0 !== cy) stable = 0;
    end
    bus.cfg_update = 1'b0;
    bus.cam_eof    = 1'b0;
    gate_end = bus.frame_gate;
    res = 0;
    if (run) begin
      repeat (res_dly - 1) tick();
      bus.res_beat = 1'b1;
      tick();
      bus.res_beat = 1'b0;
      res = bus.result_pulse;
    end
    tick();
  endtask

  // Bring the model's decimation phase back to zero with unchecked frames
  task automatic drain_decim();
    bit r, a, an, g, ge, s, rs;
    logic [7:0] x;
    logic [6:0] y;
    set_decim(0);
    while (m_dec != 0) begin
      model_frame(0, 0, 8'd0, 7'd0, r);
      drive_frame(r, 6, 10, 0, 0, 8'd0, 7'd0, a, an, g, ge, x, y, s, rs);
    end
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if ({bus.ap_start, bus.frame_gate, bus.pipe_rst, bus.busy, bus.result_pulse,
         bus.timeout_err, bus.crop_x0, bus.crop_y0} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b_%b_%b_%b_%b_%b x=%0d y=%0d required all zero",
               bus.ap_start, bus.frame_gate, bus.pipe_rst, bus.busy, bus.result_pulse,
               bus.timeout_err, bus.crop_x0, bus.crop_y0);
    end
    checks++;
    if ({bus.frames_seen, bus.frames_run, bus.frames_dropped} !== 48'd0) begin
      errors++;
      $display("FAIL reset_counters: got %0d/%0d/%0d required 0/0/0",
               bus.frames_seen, bus.frames_run, bus.frames_dropped);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_every_frame();
    bit r, a, an, g, ge, s, rs;
    logic [7:0] x;
    logic [6:0] y;
    set_decim(0);
    bus.enable = 1'b1;
    tick(); tick();
    for (int f = 0; f < 3; f++) begin
      model_frame(0, 0, 8'd0, 7'd0, r);
      drive_frame(r, 20, 100, 0, 0, 8'd0, 7'd0, a, an, g, ge, x, y, s, rs);
      checks++;
      if ({a, an, g, ge, rs} !== {r, 1'b0, r, 1'b0, r}) begin
        errors++;
        $display("FAIL every_frame[%0d] ap/ap_next/gate/gate_end/res: got %b%b%b%b%b required %b00%b0%b",
                 f, a, an, g, ge, rs, r, r, r);
      end
    end
    checks++;
    if ({bus.frames_seen, bus.frames_run, bus.frames_dropped} !==
        {16'(m_seen), 16'(m_run), 16'(m_drop)}) begin
      errors++;
      $display("FAIL every_frame_counters: got %0d/%0d/%0d required %0d/%0d/%0d",
               bus.frames_seen, bus.frames_run, bus.frames_dropped, m_seen, m_run, m_drop);
    end
  endtask

  task automatic test_decimation();
    bit r, a, an, g, ge, s, rs;
    logic [7:0] x;
    logic [6:0] y;
    set_decim(2);
    for (int f = 0; f < 9; f++) begin
      model_frame(0, 0, 8'd0, 7'd0, r);
      drive_frame(r, 12, 30, 0, 0, 8'd0, 7'd0, a, an, g, ge, x, y, s, rs);
      checks++;
      if ({a, g, rs} !== {r, r, r}) begin
        errors++;
        $display("FAIL decim_frame[%0d] ap/gate/res: got %b%b%b required %b%b%b",
                 f, a, g, rs, r, r, r);
      end
    end
    checks++;
    if ({bus.frames_seen, bus.frames_run, bus.frames_dropped} !==
        {16'(m_seen), 16'(m_run), 16'(m_drop)}) begin
      errors++;
      $display("FAIL decim_counters: got %0d/%0d/%0d required %0d/%0d/%0d",
               bus.frames_seen, bus.frames_run, bus.frames_dropped, m_seen, m_run, m_drop);
    end
  endtask

  task automatic test_cfg_update();
    bit r, a, an, g, ge, s, rs;
    logic [7:0] x, nx;
    logic [6:0] y, ny;
    drain_decim();
    nx = 8'($urandom_range(60, 159));
    ny = 7'($urandom_range(30, 99));
    for (int f = 0; f < 4; f++) begin
      // f0: update mid-stream, f1: update in the ARM cycle, f2/f3: no update
      if (f == 0) begin
        model_frame(1, 0, 8'd40, 7'd20, r);
        drive_frame(r, 16, 20, 1, 0, 8'd40, 7'd20, a, an, g, ge, x, y, s, rs);
      end else begin
        model_frame(0, f == 1, nx, ny, r);
        drive_frame(r, 16, 20, 0, f == 1, nx, ny, a, an, g, ge, x, y, s, rs);
      end
      checks++;
      if ({x, y, s, a} !== {m_cx, m_cy, 1'b1, r}) begin
        errors++;
        $display("FAIL cfg_frame[%0d] crop/stable/ap: got %0d,%0d,%b,%b required %0d,%0d,1,%b",
                 f, x, y, s, a, m_cx, m_cy, r);
      end
    end
  endtask

  task automatic test_random();
    bit r, a, an, g, ge, s, rs, cm, ca;
    logic [7:0] x, nx;
    logic [6:0] y, ny;
    int len, dly;
    for (int f = 0; f < 16; f++) begin
      if ($urandom_range(0, 3) == 0) set_decim(int'($urandom_range(0, 3)));
      cm  = ($urandom_range(0, 3) == 0);
      ca  = ($urandom_range(0, 3) == 0);
      nx  = 8'($urandom_range(0, 159));
      ny  = 7'($urandom_range(0, 99));
      len = int'($urandom_range(4, 40));
      dly = int'($urandom_range(1, 150));
      model_frame(cm, ca, nx, ny, r);
      drive_frame(r, len, dly, cm, ca, nx, ny, a, an, g, ge, x, y, s, rs);
      checks++;
      if ({a, an, g, ge, rs, s, x, y} !== {r, 1'b0, r, 1'b0, r, 1'b1, m_cx, m_cy}) begin
        errors++;
        $display("FAIL random_frame[%0d] ap=%b ap_next=%b gate=%b gate_end=%b res=%b stable=%b crop=%0d,%0d required run=%b crop=%0d,%0d",
                 f, a, an, g, ge, rs, s, x, y, r, m_cx, m_cy);
      end
    end
    checks++;
    if ({bus.frames_seen, bus.frames_run, bus.frames_dropped} !==
        {16'(m_seen), 16'(m_run), 16'(m_drop)}) begin
      errors++;
      $display("FAIL random_counters: got %0d/%0d/%0d required %0d/%0d/%0d",
               bus.frames_seen, bus.frames_run, bus.frames_dropped, m_seen, m_run, m_drop);
    end
  endtask

  task automatic test_sof_in_result();
    bit r, a, an, g, ge, s, rs, stray;
    logic [7:0] x;
    logic [6:0] y;
    drain_decim();
    model_frame(0, 0, 8'd0, 7'd0, r);
    bus.cam_sof = 1'b1;
    tick();
    bus.cam_sof = 1'b0;
    checks++;
    if (bus.ap_start !== r) begin
      errors++;
      $display("FAIL sofres_launch: got ap_start=%b required %b", bus.ap_start, r);
    end
    tick();
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      bus.res_beat = (i == 2);       // stray result while streaming
      bus.cam_eof  = (i == 7);
      tick();
      if (bus.result_pulse === 1'b1) stray = 1;
    end
    bus.res_beat = 1'b0;
    bus.cam_eof  = 1'b0;
    checks++;
    if (stray !== 1'b0) begin
      errors++;
      $display("FAIL stray_res_beat: got result_pulse in STREAM required none");
    end
    bus.cam_sof = 1'b1;
    tick();
    bus.cam_sof = 1'b0;
    m_seen++;
    m_drop++;
    checks++;
    if ({bus.ap_start, bus.busy} !== 2'b01) begin
      errors++;
      $display("FAIL sofres_no_launch: got ap_start=%b busy=%b required 0 1", bus.ap_start, bus.busy);
    end
    repeat (4) tick();
    bus.res_beat = 1'b1;
    tick();
    bus.res_beat = 1'b0;
    checks++;
    if (bus.result_pulse !== 1'b1) begin
      errors++;
      $display("FAIL sofres_result: got result_pulse=%b required 1", bus.result_pulse);
    end
    tick();
    checks++;
    if ({bus.frames_seen, bus.frames_run, bus.frames_dropped} !==
        {16'(m_seen), 16'(m_run), 16'(m_drop)}) begin
      errors++;
      $display("FAIL sofres_counters: got %0d/%0d/%0d required %0d/%0d/%0d",
               bus.frames_seen, bus.frames_run, bus.frames_dropped, m_seen, m_run, m_drop);
    end
    // The stray SOF must not have advanced the decimation phase
    model_frame(0, 0, 8'd0, 7'd0, r);
    drive_frame(r, 8, 10, 0, 0, 8'd0, 7'd0, a, an, g, ge, x, y, s, rs);
    checks++;
    if ({a, rs} !== {r, r}) begin
      errors++;
      $display("FAIL sofres_next_frame: got ap=%b res=%b required %b %b", a, rs, r, r);
    end
  endtask

  task automatic test_timeout_race();
    bit r;
    int n;
    drain_decim();
    model_frame(0, 0, 8'd0, 7'd0, r);
    bus.cam_sof = 1'b1;
    tick();
    bus.cam_sof = 1'b0;
    n = 0;
    checks++;
    if (bus.ap_start !== r) begin
      errors++;
      $display("FAIL race_launch: got ap_start=%b required %b", bus.ap_start, r);
    end
    for (int i = 0; i < 10; i++) begin
      bus.cam_eof = (i == 9);
      tick();
      n++;
    end
    bus.cam_eof = 1'b0;
    while (n < int'(TO)) begin tick(); n++; end
    // res_beat sampled on the last allowed cycle
    bus.res_beat = 1'b1;
    tick();
    bus.res_beat = 1'b0;
    checks++;
    if ({bus.result_pulse, bus.pipe_rst, bus.timeout_err} !== 3'b100) begin
      errors++;
      $display("FAIL race_result: got result/pipe_rst/err=%b%b%b required 100",
               bus.result_pulse, bus.pipe_rst, bus.timeout_err);
    end
    tick();
    checks++;
    if ({bus.pipe_rst, bus.busy} !== 2'b00) begin
      errors++;
      $display("FAIL race_no_flush: got pipe_rst=%b busy=%b required 0 0", bus.pipe_rst, bus.busy);
    end
  endtask

  task automatic test_timeout();
    bit r, a, an, g, ge, s, rs;
    logic [7:0] x;
    logic [6:0] y;
    int n, fl;
    drain_decim();
    model_frame(0, 0, 8'd0, 7'd0, r);
    bus.cam_sof = 1'b1;
    tick();
    bus.cam_sof = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      bus.cam_eof = (i == 9);
      tick();
      n++;
    end
    bus.cam_eof = 1'b0;
    while (bus.pipe_rst !== 1'b1 && n < 2 * int'(TO)) begin tick(); n++; end
    checks++;
    if (n != int'(TO) + 1) begin
      errors++;
      $display("FAIL timeout_latency: got flush %0d cycles after ap_start required %0d", n, TO + 1);
    end
    checks++;
    if ({bus.timeout_err, bus.frame_gate, bus.busy} !== 3'b101) begin
      errors++;
      $display("FAIL timeout_flags: got err/gate/busy=%b%b%b required 101",
               bus.timeout_err, bus.frame_gate, bus.busy);
    end
    // A SOF during flush is neither counted nor launched
    fl = 0;
    bus.cam_sof = 1'b1;
    while (bus.pipe_rst === 1'b1 && fl < 4 * int'(FL)) begin
      tick();
      bus.cam_sof = 1'b0;
      fl++;
    end
    bus.cam_sof = 1'b0;
    checks++;
    if (fl != int'(FL)) begin
      errors++;
      $display("FAIL flush_length: got pipe_rst high %0d cycles required %0d", fl, FL);
    end
    checks++;
    if ({bus.busy, bus.timeout_err, bus.frames_seen, bus.frames_run} !==
        {1'b0, 1'b1, 16'(m_seen), 16'(m_run)}) begin
      errors++;
      $display("FAIL after_flush: got busy=%b err=%b seen=%0d run=%0d required 0 1 %0d %0d",
               bus.busy, bus.timeout_err, bus.frames_seen, bus.frames_run, m_seen, m_run);
    end
    tick();
    model_frame(0, 0, 8'd0, 7'd0, r);
    drive_frame(r, 8, 10, 0, 0, 8'd0, 7'd0, a, an, g, ge, x, y, s, rs);
    checks++;
    if ({a, rs, bus.timeout_err} !== {r, r, 1'b1}) begin
      errors++;
      $display("FAIL relaunch_after_flush: got ap=%b res=%b err=%b required %b %b 1",
               a, rs, bus.timeout_err, r, r);
    end
    bus.enable = 1'b0;
    tick();
    checks++;
    if (bus.timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear_on_disable: got timeout_err=%b required 0", bus.timeout_err);
    end
    tick();
  endtask

  task automatic test_reset_mid_stream();
    bit r, a, an, g, ge, s, rs;
    logic [7:0] x;
    logic [6:0] y;
    bus.enable = 1'b1;
    tick(); tick();
    drain_decim();
    model_frame(0, 0, 8'd0, 7'd0, r);
    bus.cam_sof = 1'b1;
    tick();
    bus.cam_sof = 1'b0;
    tick();
    checks++;
    if ({bus.frame_gate, bus.busy} !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset_stream: got gate=%b busy=%b required 1 1", bus.frame_gate, bus.busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.frame_gate, bus.ap_start, bus.busy, bus.pipe_rst} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset_ctrl: got gate/ap/busy/pipe_rst=%b%b%b%b required 0000",
               bus.frame_gate, bus.ap_start, bus.busy, bus.pipe_rst);
    end
    checks++;
    if ({bus.frames_seen, bus.frames_run, bus.frames_dropped} !== 48'd0) begin
      errors++;
      $display("FAIL async_reset_counters: got %0d/%0d/%0d required 0/0/0",
               bus.frames_seen, bus.frames_run, bus.frames_dropped);
    end
    tick();
    reset = 1'b0;
    model_reset();
    tick(); tick();
    model_frame(0, 0, 8'd0, 7'd0, r);
    drive_frame(r, 8, 10, 0, 0, 8'd0, 7'd0, a, an, g, ge, x, y, s, rs);
    checks++;
    if ({a, rs, bus.frames_run} !== {r, r, 16'(m_run)}) begin
      errors++;
      $display("FAIL post_reset_frame: got ap=%b res=%b run=%0d required %b %b %0d",
               a, rs, bus.frames_run, r, r, m_run);
    end
  endtask

  initial begin
    reset           = 1'b1;
    bus.enable      = 1'b0;
    bus.decim       = 8'd0;
    bus.cfg_crop_x0 = '0;
    bus.cfg_crop_y0 = '0;
    bus.cfg_update  = 1'b0;
    bus.cam_sof     = 1'b0;
    bus.cam_eof     = 1'b0;
    bus.res_beat    = 1'b0;
    m_decim         = 0;
    model_reset();
    test_reset();
    test_every_frame();
    test_decimation();
    test_cfg_update();
    test_random();
    test_sof_in_result();
    test_timeout_race();
    test_timeout();
    test_reset_mid_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete within 2 ms");
    $fatal(1);
  end
endmodule
